// File: rtl/phy_rx_serial_paralelo.sv
// Receive-side lane deserializer: bit-granular comma hunt, comma-run sync,
// then byte delivery with a per-boundary strobe once the lane is active.
module phy_rx_serial_paralelo #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter int         COMMA_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active_out
);

    localparam logic [2:0] CNT_LOCK = 3'(COMMA_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] comma_cnt_q, comma_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;
    logic       active_q, active_d;

    logic [7:0] cand;
    logic       boundary;
    logic       is_comma;

    assign cand     = {shift_q[6:0], serial_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_comma = (cand == COMMA);

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 3'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= cand;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
            active_q    <= active_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;
        unique case (state_q)
            HUNT: begin
                // Any bit position may start a comma; a hit realigns the byte counter.
                if (is_comma) begin
                    bit_cnt_d   = 3'd0;
                    comma_cnt_d = 3'd1;
                    state_d     = (CNT_LOCK == 3'd1) ? ACTIVE : SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + 3'd1;
                        if (comma_cnt_d == CNT_LOCK) state_d = ACTIVE;
                    end else begin
                        comma_cnt_d = 3'd0;
                        state_d     = HUNT;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (is_comma) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = cand;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
        active_d = (state_d == ACTIVE);
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active_out  = active_q;

endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// Directed bench for the lane deserializer: reset, lock, data, relock, async reset.
module tb_phy_rx_serial_paralelo;

    logic       clk_8f = 1'b0;
    logic       reset  = 1'b0;
    logic       serial_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active_out;

    int n_vec = 0;
    int n_err = 0;

    phy_rx_serial_paralelo dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active_out  (active_out)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive v[n-1:0] MSB first; returns 1 ns after the edge sampling the last bit.
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk_8f);
            serial_in = v[i];
            @(posedge clk_8f);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                           input logic s, input logic a);
        chk({tag, ".data"},   {24'h0, data_out},    {24'h0, d});
        chk({tag, ".valid"},  {31'h0, valid_out},   {31'h0, v});
        chk({tag, ".strobe"}, {31'h0, byte_strobe}, {31'h0, s});
        chk({tag, ".active"}, {31'h0, active_out},  {31'h0, a});
    endtask

    task automatic do_reset();
        @(negedge clk_8f);
        reset = 1'b0;
        serial_in = 1'b0;
        repeat (2) @(posedge clk_8f);
        @(negedge clk_8f);
        reset = 1'b1;
    endtask

    initial begin
        // 1: reset held
        repeat (4) @(posedge clk_8f);
        #1;
        chk_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_8f);
        reset = 1'b1;

        // 2: lock then two data bytes
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        chk_out("t2.bc3", 8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'hBC);
        chk_out("t2.bc4", 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'hA4);
        chk_out("t2.a4", 8'hA4, 1'b1, 1'b1, 1'b1);
        send_bits(8'h01, 1);
        chk_out("t2.pulse", 8'hA4, 1'b1, 1'b0, 1'b1);
        send_bits(8'h7F, 7);
        chk_out("t2.ff", 8'hFF, 1'b1, 1'b1, 1'b1);

        // 3: comma / data / comma while active
        send_byte(8'hBC);
        chk_out("t3.bc", 8'hFF, 1'b0, 1'b1, 1'b1);
        send_byte(8'hEE);
        chk_out("t3.ee", 8'hEE, 1'b1, 1'b1, 1'b1);
        send_byte(8'hBC);
        chk_out("t3.bc2", 8'hEE, 1'b0, 1'b1, 1'b1);

        // 4: bit offset before the comma run
        do_reset();
        send_bits(8'h05, 3);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        chk_out("t4.lock", 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h32);
        chk_out("t4.32", 8'h32, 1'b1, 1'b1, 1'b1);

        // 5: broken comma run, then relock
        do_reset();
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'h00);
        chk_out("t5.break", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        chk_out("t5.bc3", 8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'hBC);
        chk_out("t5.lock", 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h01);
        chk_out("t5.01", 8'h01, 1'b1, 1'b1, 1'b1);

        // 6: async reset mid-byte while active
        send_bits(8'h05, 3);
        #2 reset = 1'b0;
        #1;
        chk_out("t6.async", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_8f);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC);
            chk_out("t6.relock", 8'h00, 1'b0, 1'b0, 1'b0);
        end
        send_byte(8'hBC);
        chk_out("t6.lock", 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h5A);
        chk_out("t6.5a", 8'h5A, 1'b1, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
